// File: rtl/lsu_mem_arbiter.sv
// Single-port data-memory arbiter between committed stores and the oldest issuable load.
// One request is in flight at a time, and a streak counter bounds how long stores can starve loads.
module lsu_mem_arbiter #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned ROB_TAG_WIDTH = 32,
   parameter int unsigned LDQ_SIZE      = 16,
   parameter int unsigned STQ_SIZE      = 16,
   parameter int unsigned STARVE_LIMIT  = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [LDQ_SIZE-1:0]                    ldq_valid,
   input  logic [LDQ_SIZE-1:0]                    ldq_address_valid,
   input  logic [LDQ_SIZE-1:0]                    ldq_executed,
   input  logic [LDQ_SIZE-1:0]                    ldq_order_fail,
   input  logic [LDQ_SIZE-1:0][XLEN-1:0]          ldq_address,
   input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] ldq_rob_tag,
   input  logic [$clog2(LDQ_SIZE)-1:0]            ldq_head,
   input  logic                                   stq_req_valid,
   input  logic [XLEN-1:0]                        stq_req_addr,
   input  logic [XLEN-1:0]                        stq_req_data,
   input  logic [$clog2(STQ_SIZE)-1:0]            stq_req_index,
   output logic                                   stq_req_ready,
   output logic                                   mem_req_valid,
   input  logic                                   mem_req_ready,
   output logic                                   mem_req_write,
   output logic [XLEN-1:0]                        mem_req_addr,
   output logic [XLEN-1:0]                        mem_req_wdata,
   output logic [ROB_TAG_WIDTH-1:0]               mem_req_tag,
   output logic                                   load_executed,
   output logic [ROB_TAG_WIDTH-1:0]               load_executed_rob_tag
);

   localparam int unsigned LDQ_IW   = $clog2(LDQ_SIZE);
   localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   logic [0:0]               state, state_nxt;
   logic [STREAK_W-1:0]      streak, streak_nxt;
   logic                     write_nxt;
   logic [XLEN-1:0]          addr_nxt, wdata_nxt;
   logic [ROB_TAG_WIDTH-1:0] tag_nxt;

   logic [LDQ_SIZE-1:0]      eligible;
   logic                     load_found;
   logic [LDQ_IW-1:0]        load_idx;
   logic [LDQ_IW-1:0]        scan_idx;
   logic                     handshake;

   assign eligible = ldq_valid & ldq_address_valid & ~ldq_executed & ~ldq_order_fail;

   // Oldest eligible load: scan from the head with natural modulo wrap of the index.
   always_comb begin
      load_found = 1'b0;
      load_idx   = '0;
      scan_idx   = '0;
      for (int i = 0; i < int'(LDQ_SIZE); i++) begin
         scan_idx = ldq_head + LDQ_IW'(i);
         if (!load_found && eligible[scan_idx]) begin
            load_found = 1'b1;
            load_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;
      write_nxt  = mem_req_write;
      addr_nxt   = mem_req_addr;
      wdata_nxt  = mem_req_wdata;
      tag_nxt    = mem_req_tag;
      case (state)
         IDLE: begin
            if (stq_req_valid || load_found) begin
               state_nxt = REQ;
               // Store goes first unless it has already starved an eligible load long enough.
               if (stq_req_valid && ((streak < STREAK_MAX) || !load_found)) begin
                  write_nxt = 1'b1;
                  addr_nxt  = stq_req_addr;
                  wdata_nxt = stq_req_data;
                  tag_nxt   = ROB_TAG_WIDTH'(stq_req_index);
                  if (!load_found)
                     streak_nxt = '0;
                  else if (streak != STREAK_MAX)
                     streak_nxt = streak + STREAK_W'(1);
               end else begin
                  write_nxt  = 1'b0;
                  addr_nxt   = ldq_address[load_idx];
                  wdata_nxt  = '0;
                  tag_nxt    = ldq_rob_tag[load_idx];
                  streak_nxt = '0;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) begin
               state_nxt = IDLE;
               write_nxt = 1'b0;
               addr_nxt  = '0;
               wdata_nxt = '0;
               tag_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         streak        <= '0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_tag   <= '0;
      end else begin
         state         <= state_nxt;
         streak        <= streak_nxt;
         mem_req_write <= write_nxt;
         mem_req_addr  <= addr_nxt;
         mem_req_wdata <= wdata_nxt;
         mem_req_tag   <= tag_nxt;
      end
   end

   assign mem_req_valid         = (state == REQ);
   assign handshake             = mem_req_valid & mem_req_ready;
   assign load_executed         = handshake & ~mem_req_write;
   assign stq_req_ready         = handshake & mem_req_write;
   assign load_executed_rob_tag = load_executed ? mem_req_tag : '0;

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Arbitrates the single data-memory request port between committed stores draining from the store queue and speculative loads waiting in the load queue. Each cycle it selects the oldest issuable load, with age measured from the load-queue head. It also picks up the store queue's pending write. It issues one request at a time with a valid/ready handshake and reports load issue back to the load queue through `load_executed`/`load_executed_rob_tag`.

## Interface
- XLEN, 32, data/address width
- ROB_TAG_WIDTH, 32, ROB tag width; also the width of the memory request tag
- LDQ_SIZE, 16, load queue depth (power of two)
- STQ_SIZE, 16, store queue depth (power of two)
- STARVE_LIMIT, 4, maximum consecutive store grants while a load is eligible

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- ldq_valid, ldq_address_valid, ldq_executed, ldq_order_fail  in  LDQ_SIZE each  per-entry load-queue status bits
- ldq_address  in  LDQ_SIZE×XLEN  per-entry load address
- ldq_rob_tag  in  LDQ_SIZE×ROB_TAG_WIDTH  per-entry ROB tag
- ldq_head  in  $clog2(LDQ_SIZE)  load-queue head pointer (oldest entry)
- stq_req_valid  in  1  store queue has a committed store to write
- stq_req_addr  in  XLEN  store address
- stq_req_data  in  XLEN  store data
- stq_req_index  in  $clog2(STQ_SIZE)  store-queue index of that store
- stq_req_ready  out  1  store accepted by memory this cycle
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = store, 0 = load
- mem_req_addr  out  XLEN  request address
- mem_req_wdata  out  XLEN  store data; 0 for loads
- mem_req_tag  out  ROB_TAG_WIDTH  load ROB tag, or zero-extended stq_req_index for stores
- load_executed  out  1  load accepted by memory this cycle
- load_executed_rob_tag  out  ROB_TAG_WIDTH  ROB tag of that load

## Operation
- Eligible load i: ldq_valid & ldq_address_valid & !ldq_executed & !ldq_order_fail.
- Load selection: the first eligible index scanning ldq_head, ldq_head+1, … modulo LDQ_SIZE. Wrap-around is required.
- FSM state IDLE:
  - If neither a store nor an eligible load is present, stay in IDLE.
  - Otherwise pick a winner:
    - The store wins if stq_req_valid and streak < STARVE_LIMIT.
    - Else the load wins if one is eligible.
    - Else the store wins.
  - Latch the winner's fields into the request registers and go to REQ.
- FSM state REQ:
  - mem_req_valid=1 and all request fields are held stable until mem_req_ready.
  - On the handshake edge, return to IDLE and clear all request fields to 0.
- Handshake outputs (combinational):
  - load_executed = mem_req_valid & mem_req_ready & !mem_req_write.
  - stq_req_ready = mem_req_valid & mem_req_ready & mem_req_write.
  - load_executed_rob_tag = mem_req_tag while load_executed=1, else 0.
- streak counter, width $clog2(STARVE_LIMIT+1), updated at winner latch:
  - On a store grant with ≥1 eligible load: increment, saturating at STARVE_LIMIT.
  - On a store grant with no eligible load: clear to 0.
  - On a load grant: clear to 0.
- An inflight load stays in REQ even if its entry becomes invalid or gets order_fail; the load queue discards the late executed update.
- stq_req_valid must stay high until stq_req_ready. A store entry is never withdrawn.
- Reset, asynchronous at any time including mid-handshake:
  - state=IDLE, streak=0.
  - mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_tag = 0.
  - load_executed, load_executed_rob_tag, stq_req_ready = 0.
  - No handshake pulse is produced for an aborted request.

## Timing
- A request is issued 1 cycle after it becomes eligible: eligibility in cycle N gives mem_req_valid in cycle N+1.
- Handshake completes in the same cycle mem_req_ready is high.
- The executed bit in the load queue updates on that edge. IDLE re-selection in the following cycle therefore excludes the just-issued load.
- Maximum throughput: one request every 2 cycles.
- Load-to-memory latency is unbounded and governed by mem_req_ready.

## Test plan
- Reset, then make entry 3 eligible (addr 0x100, tag 7) → mem_req_valid, addr 0x100, tag 7, write=0 the next cycle. With mem_req_ready=1 → load_executed=1, tag 7 for exactly one cycle.
- head=14; entries 15 and 1 eligible → entry 15 issues first, then entry 1 (wrap-around age order).
- stq_req_valid held high (addr 0x200, data 0xDEAD, index 5) while a load stays eligible → 4 store grants with mem_req_tag=5 and stq_req_ready pulses, then the load is granted, then stores resume.
- mem_req_ready=0 for 5 cycles during a load request → address, tag and write stay stable and no load_executed pulse. Ready on the 6th cycle → a single pulse.
- Assert reset in REQ before ready → all outputs are 0 immediately and the FSM is in IDLE. After release, the same still-eligible load is re-issued.
- Entry eligible but ldq_order_fail=1 (or address_valid=0) → mem_req_valid stays 0.
